// File: rtl/simple_rs_pkg.sv
// Shared reservation-station package.
// Holds the queue-type enum, operand and command structs and the default field
// widths used by the station and every execution unit (load, execute, store).
// Also holds the load-unit FSM state encoding.
package simple_rs_pkg;

   // Default widths for the station command fields
   localparam int RS_ADDR_W = 16;
   localparam int RS_LEN_W  = 16;
   localparam int RS_ROB_W  = 3;

   // Which execution queue a station entry is dispatched to
   typedef enum logic [1:0] {
      Q_LD = 2'd0,
      Q_EX = 2'd1,
      Q_ST = 2'd2
   } q_type_e;

   // One operand descriptor: a region of memory starting at 'start'
   typedef struct packed {
      logic                 valid;
      logic [RS_ADDR_W-1:0] start;
      logic [RS_LEN_W-1:0]  len;
   } operand_t;

   // Full command as it sits in the reservation station
   typedef struct packed {
      q_type_e             q_type;
      operand_t            opa;
      operand_t            opb;
      logic [RS_ROB_W-1:0] rob_id;
   } rs_cmd_t;

   // Load unit control states
   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_RUN  = 2'd1,
      LD_DONE = 2'd2
   } ld_state_e;

endpackage : simple_rs_pkg

// File: rtl/load_inflight_ctr.sv
// Up/down counter of outstanding memory requests with a full flag.
// Shared by the load and store units.
// Ports:
//   clock, reset (async active-low)
//   clr   : synchronous clear (takes priority over inc/dec)
//   inc   : one request issued
//   dec   : one response retired
//   full  : count has reached MAX_CNT
// Simultaneous inc and dec leave the count unchanged. Callers gate inc with
// full, so the count never passes MAX_CNT.
module load_inflight_ctr #(
   parameter int MAX_CNT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   input  logic dec,
   output logic full
);

   localparam int CNT_W = $clog2(MAX_CNT + 1);

   logic [CNT_W-1:0] count_r;

   // Outstanding-request count register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         count_r <= {CNT_W{1'b0}};
      end else if (inc && !dec) begin
         count_r <= count_r + CNT_W'(1);
      end else if (dec && !inc) begin
         count_r <= count_r - CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign full = (count_r == CNT_W'(MAX_CNT));

endmodule : load_inflight_ctr

// File: rtl/simple_load_unit_chk.sv
// Protocol checker for simple_load_unit, instantiated alongside the unit.
// Ports: the unit's clock/reset plus the memory and completion handshake signals.
// Flags responses that outnumber issued requests, and a completion that
// changes or drops before it is accepted.
module simple_load_unit_chk #(
   parameter int LEN_W = 16,
   parameter int ROB_W = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_mem_req_valid,
   input  logic             io_mem_req_ready,
   input  logic             io_mem_resp_valid,
   input  logic             io_busy,
   input  logic             io_done_valid,
   input  logic             io_done_ready,
   input  logic [ROB_W-1:0] io_done_robId
);

   localparam int OUT_W = LEN_W + 2;

   logic [OUT_W-1:0] outstanding_r;
   logic             req_fire_s;
   logic             resp_take_s;

   assign req_fire_s  = io_mem_req_valid && io_mem_req_ready;
   assign resp_take_s = io_mem_resp_valid && io_busy;

   // Track requests issued but not yet answered, as seen on the ports
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         outstanding_r <= {OUT_W{1'b0}};
      end else if (req_fire_s && !resp_take_s) begin
         outstanding_r <= outstanding_r + OUT_W'(1);
      end else if (resp_take_s && !req_fire_s) begin
         outstanding_r <= outstanding_r - OUT_W'(1);
      end else begin
         outstanding_r <= outstanding_r;
      end
   end

   a_no_excess_resp: assert property (@(posedge clock) disable iff (!reset)
      resp_take_s |-> (outstanding_r != {OUT_W{1'b0}}));

   a_done_stable: assert property (@(posedge clock) disable iff (!reset)
      (io_done_valid && !io_done_ready) |=> (io_done_valid && $stable(io_done_robId)));

endmodule : simple_load_unit_chk

// File: rtl/simple_load_unit.sv
// Load execution stage fed by the reservation station's load issue port.
// Copies opb_len words from DRAM (opb_start..) into the scratchpad (opa_start..),
// keeping up to MAX_INFLIGHT reads outstanding, then reports the robId on the
// completion port.
// Ports:
//   clock, reset (async active-low)
//   io_cmd_*       : command from the station (valid/ready, operands, robId)
//   io_mem_req_*   : DRAM read request (valid/ready, word address)
//   io_mem_resp_*  : DRAM read data, in order, no backpressure
//   io_spad_wr_*   : scratchpad write port, driven in the response cycle
//   io_done_*      : completion (valid/ready, robId)
//   io_busy        : unit is not idle
// Optional feature macro LOAD_UNIT_PERF_EN adds saturating 32-bit counters
//   io_perf_busy_cycles (cycles not idle) and io_perf_cmds (completions accepted).
module simple_load_unit
   import simple_rs_pkg::*;
#(
   parameter int ADDR_W       = RS_ADDR_W,
   parameter int LEN_W        = RS_LEN_W,
   parameter int DATA_W       = 32,
   parameter int ROB_W        = RS_ROB_W,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_cmd_valid,
   output logic              io_cmd_ready,
   input  logic              io_cmd_opa_valid,
   input  logic [ADDR_W-1:0] io_cmd_opa_start,
   input  logic              io_cmd_opb_valid,
   input  logic [ADDR_W-1:0] io_cmd_opb_start,
   input  logic [LEN_W-1:0]  io_cmd_opb_len,
   input  logic [ROB_W-1:0]  io_cmd_robId,
   output logic              io_mem_req_valid,
   input  logic              io_mem_req_ready,
   output logic [ADDR_W-1:0] io_mem_req_addr,
   input  logic              io_mem_resp_valid,
   input  logic [DATA_W-1:0] io_mem_resp_data,
   output logic              io_spad_wr_en,
   output logic [ADDR_W-1:0] io_spad_wr_addr,
   output logic [DATA_W-1:0] io_spad_wr_data,
   output logic              io_done_valid,
   input  logic              io_done_ready,
   output logic [ROB_W-1:0]  io_done_robId,
   output logic              io_busy
`ifdef LOAD_UNIT_PERF_EN
   ,
   output logic [31:0]       io_perf_busy_cycles,
   output logic [31:0]       io_perf_cmds
`endif
);

   // One extra bit so a length of 2^LEN_W-1 can be counted up to without wrap
   localparam int CNT_W = LEN_W + 1;

   ld_state_e         state_r;
   ld_state_e         state_nxt_s;
   logic [ADDR_W-1:0] opa_start_r;
   logic [ADDR_W-1:0] opb_start_r;
   logic [CNT_W-1:0]  len_r;
   logic [ROB_W-1:0]  rob_r;
   logic [CNT_W-1:0]  req_cnt_r;
   logic [CNT_W-1:0]  resp_cnt_r;

   logic cmd_fire_s;
   logic cmd_empty_s;
   logic req_fire_s;
   logic resp_fire_s;
   logic last_resp_s;
   logic inflight_full_s;

   assign cmd_fire_s  = io_cmd_valid && io_cmd_ready;
   // Nothing to copy: skip straight to completion without touching memory
   assign cmd_empty_s = (io_cmd_opb_len == {LEN_W{1'b0}}) || !io_cmd_opa_valid || !io_cmd_opb_valid;
   assign req_fire_s  = io_mem_req_valid && io_mem_req_ready;
   // Responses outside RUN (e.g. stragglers after a reset) are dropped
   assign resp_fire_s = (state_r == LD_RUN) && io_mem_resp_valid;
   assign last_resp_s = (resp_cnt_r == (len_r - CNT_W'(1)));

   load_inflight_ctr #(
      .MAX_CNT (MAX_INFLIGHT)
   ) u_inflight (
      .clock (clock),
      .reset (reset),
      .clr   (cmd_fire_s),
      .inc   (req_fire_s),
      .dec   (resp_fire_s),
      .full  (inflight_full_s)
   );

   // Control state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= LD_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         LD_IDLE: begin
            if (cmd_fire_s) begin
               state_nxt_s = cmd_empty_s ? LD_DONE : LD_RUN;
            end else begin
               state_nxt_s = LD_IDLE;
            end
         end
         LD_RUN: begin
            if (resp_fire_s && last_resp_s) begin
               state_nxt_s = LD_DONE;
            end else begin
               state_nxt_s = LD_RUN;
            end
         end
         LD_DONE: begin
            if (io_done_ready) begin
               state_nxt_s = LD_IDLE;
            end else begin
               state_nxt_s = LD_DONE;
            end
         end
         default: begin
            state_nxt_s = LD_IDLE;
         end
      endcase
   end

   // Command latch and request/response progress counters
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         opa_start_r <= {ADDR_W{1'b0}};
         opb_start_r <= {ADDR_W{1'b0}};
         len_r       <= {CNT_W{1'b0}};
         rob_r       <= {ROB_W{1'b0}};
         req_cnt_r   <= {CNT_W{1'b0}};
         resp_cnt_r  <= {CNT_W{1'b0}};
      end else if (cmd_fire_s) begin
         opa_start_r <= io_cmd_opa_start;
         opb_start_r <= io_cmd_opb_start;
         len_r       <= {1'b0, io_cmd_opb_len};
         rob_r       <= io_cmd_robId;
         req_cnt_r   <= {CNT_W{1'b0}};
         resp_cnt_r  <= {CNT_W{1'b0}};
      end else begin
         if (req_fire_s) begin
            req_cnt_r <= req_cnt_r + CNT_W'(1);
         end else begin
            req_cnt_r <= req_cnt_r;
         end
         if (resp_fire_s) begin
            resp_cnt_r <= resp_cnt_r + CNT_W'(1);
         end else begin
            resp_cnt_r <= resp_cnt_r;
         end
      end
   end

   // Port decode; the scratchpad write is combinational so data lands in the response cycle
   always_comb begin
      io_cmd_ready     = (state_r == LD_IDLE);
      io_mem_req_valid = (state_r == LD_RUN) && (req_cnt_r < len_r) && !inflight_full_s;
      // Addresses wrap modulo 2^ADDR_W
      io_mem_req_addr  = opb_start_r + ADDR_W'(req_cnt_r);
      io_spad_wr_en    = resp_fire_s;
      io_spad_wr_addr  = opa_start_r + ADDR_W'(resp_cnt_r);
      io_spad_wr_data  = io_mem_resp_data;
      io_done_valid    = (state_r == LD_DONE);
      io_done_robId    = rob_r;
      io_busy          = (state_r != LD_IDLE);
   end

`ifdef LOAD_UNIT_PERF_EN
   logic [31:0] perf_busy_r;
   logic [31:0] perf_cmds_r;

   // Saturating busy-cycle and completion counters
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_busy_r <= 32'd0;
         perf_cmds_r <= 32'd0;
      end else begin
         if ((state_r != LD_IDLE) && (perf_busy_r != 32'hFFFF_FFFF)) begin
            perf_busy_r <= perf_busy_r + 32'd1;
         end else begin
            perf_busy_r <= perf_busy_r;
         end
         if (io_done_valid && io_done_ready && (perf_cmds_r != 32'hFFFF_FFFF)) begin
            perf_cmds_r <= perf_cmds_r + 32'd1;
         end else begin
            perf_cmds_r <= perf_cmds_r;
         end
      end
   end

   assign io_perf_busy_cycles = perf_busy_r;
   assign io_perf_cmds        = perf_cmds_r;
`endif

endmodule : simple_load_unit

// File: tb/tb_simple_load_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for simple_load_unit: stimulus pushes expected requests,
// scratchpad writes and completions into queues; a negedge monitor pops and
// compares whenever the unit presents one of them.
module tb_simple_load_unit;

   localparam int ADDR_W = 16;
   localparam int LEN_W  = 16;
   localparam int DATA_W = 32;
   localparam int ROB_W  = 3;
   localparam int MAXI   = 4;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              io_cmd_valid;
   logic              io_cmd_ready;
   logic              io_cmd_opa_valid;
   logic [ADDR_W-1:0] io_cmd_opa_start;
   logic              io_cmd_opb_valid;
   logic [ADDR_W-1:0] io_cmd_opb_start;
   logic [LEN_W-1:0]  io_cmd_opb_len;
   logic [ROB_W-1:0]  io_cmd_robId;
   logic              io_mem_req_valid;
   logic              io_mem_req_ready;
   logic [ADDR_W-1:0] io_mem_req_addr;
   logic              io_mem_resp_valid;
   logic [DATA_W-1:0] io_mem_resp_data;
   logic              io_spad_wr_en;
   logic [ADDR_W-1:0] io_spad_wr_addr;
   logic [DATA_W-1:0] io_spad_wr_data;
   logic              io_done_valid;
   logic              io_done_ready;
   logic [ROB_W-1:0]  io_done_robId;
   logic              io_busy;
`ifdef LOAD_UNIT_PERF_EN
   logic [31:0]       io_perf_busy_cycles;
   logic [31:0]       io_perf_cmds;
`endif

   simple_load_unit #(
      .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .ROB_W(ROB_W), .MAX_INFLIGHT(MAXI)
   ) dut (
      .clock(clock), .reset(reset),
      .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready),
      .io_cmd_opa_valid(io_cmd_opa_valid), .io_cmd_opa_start(io_cmd_opa_start),
      .io_cmd_opb_valid(io_cmd_opb_valid), .io_cmd_opb_start(io_cmd_opb_start),
      .io_cmd_opb_len(io_cmd_opb_len), .io_cmd_robId(io_cmd_robId),
      .io_mem_req_valid(io_mem_req_valid), .io_mem_req_ready(io_mem_req_ready),
      .io_mem_req_addr(io_mem_req_addr),
      .io_mem_resp_valid(io_mem_resp_valid), .io_mem_resp_data(io_mem_resp_data),
      .io_spad_wr_en(io_spad_wr_en), .io_spad_wr_addr(io_spad_wr_addr),
      .io_spad_wr_data(io_spad_wr_data),
      .io_done_valid(io_done_valid), .io_done_ready(io_done_ready),
      .io_done_robId(io_done_robId), .io_busy(io_busy)
`ifdef LOAD_UNIT_PERF_EN
      , .io_perf_busy_cycles(io_perf_busy_cycles), .io_perf_cmds(io_perf_cmds)
`endif
   );

   simple_load_unit_chk #(.LEN_W(LEN_W), .ROB_W(ROB_W)) u_chk (
      .clock(clock), .reset(reset),
      .io_mem_req_valid(io_mem_req_valid), .io_mem_req_ready(io_mem_req_ready),
      .io_mem_resp_valid(io_mem_resp_valid), .io_busy(io_busy),
      .io_done_valid(io_done_valid), .io_done_ready(io_done_ready),
      .io_done_robId(io_done_robId)
   );

   always #5 clock = ~clock;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int cyc      = 0;

   logic [ADDR_W-1:0] exp_req_q[$];
   logic [ADDR_W-1:0] exp_wa_q[$];
   logic [DATA_W-1:0] exp_wd_q[$];
   logic [ROB_W-1:0]  exp_rob_q[$];
   logic [ADDR_W-1:0] pend_addr_q[$];
   int                pend_due_q[$];

   bit          resp_hold   = 1'b0;
   int          resp_credit = 0;
   bit          rdy_toggle  = 1'b0;
   logic [15:0] salt        = 16'h1111;
   int          req_hs_cnt  = 0;
   int          wr_seen     = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Monitor / scoreboard: compare everything the DUT presents
   always @(negedge clock) begin
      if (io_mem_req_valid && io_mem_req_ready) begin
         req_hs_cnt++;
         pend_addr_q.push_back(io_mem_req_addr);
         pend_due_q.push_back(cyc + 2);
         if (exp_req_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_req: got addr 0x%0h, expected none", io_mem_req_addr);
         end else begin
            chk("req_addr", 32'(io_mem_req_addr), 32'(exp_req_q.pop_front()));
         end
      end
      if (io_spad_wr_en) begin
         wr_seen++;
         if (exp_wa_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_wr: got addr 0x%0h, expected none", io_spad_wr_addr);
         end else begin
            chk("spad_addr", 32'(io_spad_wr_addr), 32'(exp_wa_q.pop_front()));
            chk("spad_data", io_spad_wr_data, exp_wd_q.pop_front());
         end
      end
      if (io_done_valid && io_done_ready) begin
         if (exp_rob_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_done: got rob %0d, expected none", io_done_robId);
         end else begin
            chk("done_robId", 32'(io_done_robId), 32'(exp_rob_q.pop_front()));
         end
      end
   end

   // DRAM model: in-order responses two cycles after each request handshake
   initial begin
      io_mem_resp_valid = 1'b0;
      io_mem_resp_data  = '0;
      io_mem_req_ready  = 1'b1;
      forever begin
         @(posedge clock); #1;
         io_mem_req_ready = rdy_toggle ? cyc[0] : 1'b1;
         if (pend_due_q.size() > 0 && pend_due_q[0] <= cyc && (!resp_hold || resp_credit > 0)) begin
            if (resp_hold) resp_credit--;
            io_mem_resp_valid = 1'b1;
            io_mem_resp_data  = {salt, pend_addr_q.pop_front()};
            void'(pend_due_q.pop_front());
         end else begin
            io_mem_resp_valid = 1'b0;
            io_mem_resp_data  = '0;
         end
      end
   end

   task automatic issue(input bit av, input logic [15:0] a, input bit bv, input logic [15:0] b,
                        input logic [15:0] len, input logic [2:0] rob);
      bit acc;
      if (av && bv && len != 16'd0) begin
         for (int i = 0; i < int'(len); i++) begin
            logic [15:0] ra;
            ra = b + 16'(i);
            exp_req_q.push_back(ra);
            exp_wa_q.push_back(a + 16'(i));
            exp_wd_q.push_back({salt, ra});
         end
      end
      exp_rob_q.push_back(rob);
      @(posedge clock); #1;
      io_cmd_valid = 1'b1; io_cmd_opa_valid = av; io_cmd_opa_start = a;
      io_cmd_opb_valid = bv; io_cmd_opb_start = b; io_cmd_opb_len = len; io_cmd_robId = rob;
      acc = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) begin
         @(negedge clock);
         if (io_cmd_ready) acc = 1'b1;
      end
      if (!acc) begin
         chk_cnt++;
         $display("FAIL cmd_accept: got ready=0 for 20 cycles, expected ready=1");
      end
      @(posedge clock); #1;
      io_cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int max_cyc);
      bit idle;
      idle = 1'b0;
      for (int k = 0; k < max_cyc && !idle; k++) begin
         @(negedge clock);
         if (!io_busy) idle = 1'b1;
      end
      if (!idle) begin
         chk_cnt++;
         $display("FAIL %s_timeout: got busy after %0d cycles, expected idle", name, max_cyc);
      end
      chk({name, "_queues"}, 32'(exp_req_q.size() + exp_wa_q.size() + exp_rob_q.size()), 32'd0);
   endtask

   int  base;
   bit  seen;

   initial begin
      io_cmd_valid = 1'b0; io_cmd_opa_valid = 1'b0; io_cmd_opa_start = '0;
      io_cmd_opb_valid = 1'b0; io_cmd_opb_start = '0; io_cmd_opb_len = '0;
      io_cmd_robId = '0; io_done_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      chk("rst_cmd_ready", 32'(io_cmd_ready), 32'd1);
      chk("rst_req_valid", 32'(io_mem_req_valid), 32'd0);
      chk("rst_wr_en", 32'(io_spad_wr_en), 32'd0);
      chk("rst_done_valid", 32'(io_done_valid), 32'd0);
      chk("rst_busy", 32'(io_busy), 32'd0);

      // 1: basic 4-word copy
      issue(1'b1, 16'h0100, 1'b1, 16'h2000, 16'd4, 3'd5);
      wait_idle("t1", 100);

      // 2: zero length completes the cycle after accept
      salt = 16'h2222;
      io_done_ready = 1'b0;
      issue(1'b1, 16'h0040, 1'b1, 16'h3000, 16'd0, 3'd2);
      @(negedge clock);
      chk("t2_done_valid", 32'(io_done_valid), 32'd1);
      chk("t2_cmd_ready", 32'(io_cmd_ready), 32'd0);
      chk("t2_req_valid", 32'(io_mem_req_valid), 32'd0);
      @(posedge clock); #1 io_done_ready = 1'b1;
      wait_idle("t2", 20);

      // 2b: missing scratchpad operand issues no requests
      base = req_hs_cnt;
      issue(1'b0, 16'h0040, 1'b1, 16'h3000, 16'd5, 3'd4);
      wait_idle("t2b", 20);
      chk("t2b_no_req", 32'(req_hs_cnt - base), 32'd0);

      // 3: inflight limit with responses withheld
      salt = 16'h3333;
      resp_hold = 1'b1; resp_credit = 0;
      base = req_hs_cnt;
      issue(1'b1, 16'h0500, 1'b1, 16'h4000, 16'd10, 3'd3);
      repeat (10) @(negedge clock);
      chk("t3_reqs_at_limit", 32'(req_hs_cnt - base), 32'd4);
      chk("t3_req_valid_low", 32'(io_mem_req_valid), 32'd0);
      resp_credit = 1;
      repeat (6) @(negedge clock);
      chk("t3_one_released", 32'(req_hs_cnt - base), 32'd5);
      chk("t3_req_valid_low2", 32'(io_mem_req_valid), 32'd0);
      resp_hold = 1'b0;
      wait_idle("t3", 200);

      // 4: address wrap, with request backpressure
      salt = 16'h4444;
      rdy_toggle = 1'b1;
      issue(1'b1, 16'hFFFF, 1'b1, 16'hFFFE, 16'd3, 3'd1);
      wait_idle("t4", 100);
      rdy_toggle = 1'b0;

      // 5: completion held while done_ready low; new command refused
      salt = 16'h5555;
      io_done_ready = 1'b0;
      issue(1'b1, 16'h0010, 1'b1, 16'h0020, 16'd1, 3'd6);
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clock);
         if (io_done_valid) seen = 1'b1;
      end
      chk("t5_done_seen", 32'(seen), 32'd1);
      io_cmd_valid = 1'b1; io_cmd_opa_valid = 1'b1; io_cmd_opb_valid = 1'b1;
      io_cmd_opb_len = 16'd2; io_cmd_robId = 3'd3;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         chk("t5_done_valid", 32'(io_done_valid), 32'd1);
         chk("t5_done_rob", 32'(io_done_robId), 32'd6);
         chk("t5_cmd_ready", 32'(io_cmd_ready), 32'd0);
      end
      @(posedge clock); #1;
      io_cmd_valid = 1'b0; io_done_ready = 1'b1;
      wait_idle("t5", 20);

      // 6: reset after two of six responses
      salt = 16'h6666;
      base = wr_seen;
      issue(1'b1, 16'h0700, 1'b1, 16'h6000, 16'd6, 3'd7);
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clock); #1;
         if (wr_seen >= base + 2) seen = 1'b1;
      end
      chk("t6_two_writes", 32'(seen), 32'd1);
      reset = 1'b0;
      #1;
      chk("t6_busy", 32'(io_busy), 32'd0);
      chk("t6_cmd_ready", 32'(io_cmd_ready), 32'd1);
      chk("t6_req_valid", 32'(io_mem_req_valid), 32'd0);
      chk("t6_wr_en", 32'(io_spad_wr_en), 32'd0);
      chk("t6_done_valid", 32'(io_done_valid), 32'd0);
      exp_req_q.delete(); exp_wa_q.delete(); exp_wd_q.delete(); exp_rob_q.delete();
      base = wr_seen;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      for (int k = 0; k < 20 && pend_due_q.size() > 0; k++) @(negedge clock);
      @(negedge clock);
      chk("t6_no_late_wr", 32'(wr_seen - base), 32'd0);
      salt = 16'h7777;
      issue(1'b1, 16'h0800, 1'b1, 16'h7000, 16'd3, 3'd1);
      wait_idle("t6_next", 100);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, expected end of run");
      $fatal(1);
   end

endmodule : tb_simple_load_unit
